// File: rtl/led_chaser_if.sv
// Control and LED-drive bundle for led_chaser; the chaser itself is the slave,
// whoever drives En/Mode and watches the LEDs is the master.
interface led_chaser_if #(
  parameter int N_LED = 4
);
  logic             En;
  logic [1:0]       Mode;
  logic [N_LED-1:0] LED_Out;
  logic             Step_Tick;

  modport master (
    output En,
    output Mode,
    input  LED_Out,
    input  Step_Tick
  );

  modport slave (
    input  En,
    input  Mode,
    output LED_Out,
    output Step_Tick
  );
endinterface

// File: rtl/led_chaser.sv
// LED chaser: a step prescaler with a lit window inside each step, plus a
// position/direction tracker for shift-left, shift-right, bounce and all-blink.
module led_chaser #(
  parameter int N_LED       = 4,
  parameter int STEP_CYCLES = 5_000_000,
  parameter int ON_START    = 1_250_000,
  parameter int ON_END      = 2_500_000
) (
  input  logic         CLK,
  input  logic         RSTn,
  led_chaser_if.slave  bus
);

  localparam int CNT_W = $clog2(STEP_CYCLES);
  localparam int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  if (N_LED < 1 || N_LED > 32) begin : g_badNLed
    $error("led_chaser: N_LED must be within 1..32");
  end
  if (STEP_CYCLES < 2) begin : g_badStep
    $error("led_chaser: STEP_CYCLES must be at least 2");
  end
  if (ON_START < 0 || ON_START >= ON_END || ON_END > STEP_CYCLES) begin : g_badWindow
    $error("led_chaser: need 0 <= ON_START < ON_END <= STEP_CYCLES");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [N_LED-1:0] ledOut_q, ledOut_d;
  logic             stepTick_q;

  logic             tick;
  logic             window;
  int               cntInt;
  logic [N_LED-1:0] oneHot;

  // Prescaler only moves while enabled, so a disabled chaser resumes mid-step.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.En) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick   = bus.En && (cnt_q == CNT_LAST);
  assign cntInt = int'(cnt_q);
  assign window = bus.En && (cntInt >= ON_START) && (cntInt < ON_END);

  // Mode is only looked at on a step boundary; a single LED never moves.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick && (N_LED > 1)) begin
      case (bus.Mode)
        MODE_LEFT: begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          dir_d = DIR_UP;
        end
        MODE_RIGHT: begin
          pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
          dir_d = DIR_UP;
        end
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              dir_d = DIR_DOWN;
              pos_d = pos_q - 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = pos_q + 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        default: begin
          pos_d = pos_q;
          dir_d = dir_q;
        end
      endcase
    end
  end

  // Decode uses the live Mode so a mode change shows up on the very next cycle.
  always_comb begin
    oneHot = '0;
    for (int i = 0; i < N_LED; i++) begin
      oneHot[i] = (pos_q == POS_W'(i));
    end
    ledOut_d = '0;
    if (window) begin
      ledOut_d = (bus.Mode == MODE_BLINK) ? '1 : oneHot;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q      <= '0;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      ledOut_q   <= '0;
      stepTick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      ledOut_q   <= ledOut_d;
      stepTick_q <= tick;
    end
  end

  assign bus.LED_Out   = ledOut_q;
  assign bus.Step_Tick = stepTick_q;

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: a 4-LED instance with an 8-cycle step and
// window 2..3, plus a single-LED instance for the degenerate bounce case.
module tb_led_chaser;

  logic CLK;
  logic RSTn;

  int total;
  int bad;

  led_chaser_if #(.N_LED(4)) bus4 ();
  led_chaser_if #(.N_LED(1)) bus1 ();

  led_chaser #(
    .N_LED(4), .STEP_CYCLES(8), .ON_START(2), .ON_END(4)
  ) dut4 (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus4)
  );

  led_chaser #(
    .N_LED(1), .STEP_CYCLES(8), .ON_START(2), .ON_END(4)
  ) dut1 (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Release lands on a falling edge, so the next rising edge is edge 1.
  task automatic doReset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] expLed;
    bus4.En = 1'b1; bus4.Mode = 2'b00;
    doReset();
    repeat (3) @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    total++;
    if (bus4.LED_Out !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_async_led got=%b want=%b", bus4.LED_Out, 4'b0000);
    end
    total++;
    if (bus4.Step_Tick !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_async_tick got=%b want=%b", bus4.Step_Tick, 1'b0);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge CLK); #1;
      expLed = (e >= 3) ? 4'b0001 : 4'b0000;
      total++;
      if (bus4.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL reset_first_edges e=%0d got=%b want=%b", e, bus4.LED_Out, expLed);
      end
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] expLed;
    logic       expTick;
    int s, ph;
    bus4.En = 1'b1; bus4.Mode = 2'b00;
    doReset();
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLK); #1;
      s = (e - 1) / 8; ph = (e - 1) % 8;
      expLed  = (ph == 2 || ph == 3) ? (4'b0001 << (s % 4)) : 4'b0000;
      expTick = (e % 8 == 0);
      total++;
      if (bus4.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL left_led e=%0d got=%b want=%b", e, bus4.LED_Out, expLed);
      end
      total++;
      if (bus4.Step_Tick !== expTick) begin
        bad++; $display("[TB] FAIL left_tick e=%0d got=%b want=%b", e, bus4.Step_Tick, expTick);
      end
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] expLed;
    int s, ph;
    bus4.En = 1'b1; bus4.Mode = 2'b01;
    doReset();
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLK); #1;
      s = (e - 1) / 8; ph = (e - 1) % 8;
      expLed = (ph == 2 || ph == 3) ? (4'b0001 << ((4 - (s % 4)) % 4)) : 4'b0000;
      total++;
      if (bus4.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL right_led e=%0d got=%b want=%b", e, bus4.LED_Out, expLed);
      end
    end
  endtask

  task automatic test_bounce();
    int seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    logic [3:0] expLed;
    int s, ph;
    bus4.En = 1'b1; bus4.Mode = 2'b10;
    doReset();
    for (int e = 1; e <= 64; e++) begin
      @(posedge CLK); #1;
      s = (e - 1) / 8; ph = (e - 1) % 8;
      expLed = (ph == 2 || ph == 3) ? (4'b0001 << seq[s]) : 4'b0000;
      total++;
      if (bus4.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL bounce_led e=%0d got=%b want=%b", e, bus4.LED_Out, expLed);
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] expLed;
    int ph;
    bus4.En = 1'b1; bus4.Mode = 2'b11;
    doReset();
    for (int e = 1; e <= 32; e++) begin
      @(posedge CLK); #1;
      ph = (e - 1) % 8;
      if (e <= 24) expLed = (ph == 2 || ph == 3) ? 4'b1111 : 4'b0000;
      else         expLed = (ph == 2 || ph == 3) ? 4'b0001 : 4'b0000;
      total++;
      if (bus4.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL blink_led e=%0d got=%b want=%b", e, bus4.LED_Out, expLed);
      end
      if (e == 24) bus4.Mode = 2'b00;
    end
  endtask

  task automatic test_mode_change();
    logic [3:0] expLed;
    bus4.En = 1'b1; bus4.Mode = 2'b00;
    doReset();
    for (int e = 1; e <= 24; e++) begin
      @(posedge CLK); #1;
      case (e)
        3, 12:   expLed = 4'b0001;
        4, 11:   expLed = 4'b1111;
        19, 20:  expLed = 4'b0010;
        default: expLed = 4'b0000;
      endcase
      total++;
      if (bus4.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL mode_change_led e=%0d got=%b want=%b", e, bus4.LED_Out, expLed);
      end
      if (e == 3)  bus4.Mode = 2'b11;
      if (e == 11) bus4.Mode = 2'b00;
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] expLed;
    logic       expTick;
    bus4.En = 1'b1; bus4.Mode = 2'b00;
    doReset();
    for (int e = 1; e <= 18; e++) begin
      @(posedge CLK); #1;
      case (e)
        3, 9:    expLed = 4'b0001;
        16, 17:  expLed = 4'b0010;
        default: expLed = 4'b0000;
      endcase
      expTick = (e == 13);
      total++;
      if (bus4.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL en_drop_led e=%0d got=%b want=%b", e, bus4.LED_Out, expLed);
      end
      total++;
      if (bus4.Step_Tick !== expTick) begin
        bad++; $display("[TB] FAIL en_drop_tick e=%0d got=%b want=%b", e, bus4.Step_Tick, expTick);
      end
      if (e == 3) bus4.En = 1'b0;
      if (e == 8) bus4.En = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] expLed;
    logic       expTick;
    bus4.En = 1'b1; bus4.Mode = 2'b01;
    doReset();
    repeat (19) @(posedge CLK);
    #1;
    total++;
    if (bus4.LED_Out !== 4'b0100) begin
      bad++; $display("[TB] FAIL mid_pos2_led got=%b want=%b", bus4.LED_Out, 4'b0100);
    end
    #2;
    RSTn = 1'b0;
    #1;
    total++;
    if (bus4.LED_Out !== 4'b0000) begin
      bad++; $display("[TB] FAIL mid_async_led got=%b want=%b", bus4.LED_Out, 4'b0000);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge CLK); #1;
      case (e)
        3, 4:    expLed = 4'b0001;
        11, 12:  expLed = 4'b1000;
        default: expLed = 4'b0000;
      endcase
      expTick = (e == 8 || e == 16);
      total++;
      if (bus4.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL mid_restart_led e=%0d got=%b want=%b", e, bus4.LED_Out, expLed);
      end
      total++;
      if (bus4.Step_Tick !== expTick) begin
        bad++; $display("[TB] FAIL mid_restart_tick e=%0d got=%b want=%b", e, bus4.Step_Tick, expTick);
      end
    end
  endtask

  task automatic test_single();
    logic [0:0] expLed;
    logic       expTick;
    int ph;
    bus4.En = 1'b0; bus4.Mode = 2'b00;
    bus1.En = 1'b1; bus1.Mode = 2'b10;
    doReset();
    for (int e = 1; e <= 32; e++) begin
      @(posedge CLK); #1;
      ph = (e - 1) % 8;
      expLed  = (ph == 2 || ph == 3) ? 1'b1 : 1'b0;
      expTick = (e % 8 == 0);
      total++;
      if (bus1.LED_Out !== expLed) begin
        bad++; $display("[TB] FAIL single_led e=%0d got=%b want=%b", e, bus1.LED_Out, expLed);
      end
      total++;
      if (bus1.Step_Tick !== expTick) begin
        bad++; $display("[TB] FAIL single_tick e=%0d got=%b want=%b", e, bus1.Step_Tick, expTick);
      end
    end
    bus1.En = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RSTn  = 1'b0;
    bus4.En = 1'b0; bus4.Mode = 2'b00;
    bus1.En = 1'b0; bus1.Mode = 2'b00;
    test_reset();
    test_shift_left();
    test_shift_right();
    test_bounce();
    test_blink();
    test_mode_change();
    test_enable_drop();
    test_reset_mid();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
